// File: rtl/cond_eval_unit.sv
// cond_eval_unit: checks a 4-bit branch condition code against the PSR flags.
// It waits until no flag-setting ops are pending before it evaluates.
//
// Ports:
//   clk, reset   - clock; synchronous active-high reset
//   flags        - current PSR flag word
//   alu_flags    - flag word being written this cycle (bypass build only)
//   flag_issue   - a flag-setting op was issued this cycle
//   flag_commit  - a flag-setting op writes the PSR at this edge
//   req_*        - condition request handshake (valid/ready, cond code)
//   resp_*       - result handshake (valid/ready, taken)
//   pend_cnt     - number of flag writes in flight
//   err          - sticky counter overflow/underflow
//
// Optional feature macro: COND_BYPASS_EN. When defined, a request waiting
// on the last in-flight flag write is evaluated on alu_flags at the commit
// edge. This saves one cycle.
module cond_eval_unit #(
    parameter int WIDTH    = 16,
    parameter int C_BIT    = 0,
    parameter int L_BIT    = 2,
    parameter int F_BIT    = 5,
    parameter int Z_BIT    = 6,
    parameter int N_BIT    = 7,
    parameter int MAX_PEND = 3,
    localparam int PW      = $clog2(MAX_PEND + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] flags,
    input  logic [WIDTH-1:0] alu_flags,
    input  logic             flag_issue,
    input  logic             flag_commit,
    input  logic             req_valid,
    input  logic [3:0]       req_cond,
    output logic             req_ready,
    output logic             resp_valid,
    output logic             resp_taken,
    input  logic             resp_ready,
    output logic [PW-1:0]    pend_cnt,
    output logic             err
);

    localparam logic [PW-1:0] P_MAX = PW'(MAX_PEND);
    localparam logic [PW-1:0] P_ONE = PW'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cond_q, cond_d;
    logic       taken_d;

    // Only five flag bits take part in evaluation.
    logic unused_bits;
    assign unused_bits = ^{flags, alu_flags};

    function automatic logic eval(input logic [3:0] c,
                                  input logic [WIDTH-1:0] f);
        logic r;
        logic fc, fl, ff, fz, fn;
        fc = f[C_BIT];
        fl = f[L_BIT];
        ff = f[F_BIT];
        fz = f[Z_BIT];
        fn = f[N_BIT];
        r  = 1'b0;
        unique case (c)
            4'd0:  r = fz;
            4'd1:  r = !fz;
            4'd2:  r = fc;
            4'd3:  r = !fc;
            4'd4:  r = fl;
            4'd5:  r = !fl;
            4'd6:  r = fn;
            4'd7:  r = !fn;
            4'd8:  r = ff;
            4'd9:  r = !ff;
            4'd10: r = !fl && !fz;
            4'd11: r = fl || fz;
            4'd12: r = !fn && !fz;
            4'd13: r = fn || fz;
            4'd14: r = 1'b1;
            4'd15: r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Pending flag-write counter. A simultaneous issue and commit cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_cnt <= '0;
            err      <= 1'b0;
        end else begin
            unique case ({flag_issue, flag_commit})
                2'b10: begin
                    if (pend_cnt == P_MAX) err <= 1'b1;
                    else pend_cnt <= pend_cnt + P_ONE;
                end
                2'b01: begin
                    if (pend_cnt == '0) err <= 1'b1;
                    else pend_cnt <= pend_cnt - P_ONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cond_q     <= 4'd0;
            resp_taken <= 1'b0;
        end else begin
            state_q    <= state_d;
            cond_q     <= cond_d;
            resp_taken <= taken_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cond_d     = cond_q;
        taken_d    = resp_taken;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cond_d  = req_cond;
                    state_d = WAIT;
                end
            end
            WAIT: begin
`ifdef COND_BYPASS_EN
                // The last pending write lands at this edge.
                if (pend_cnt == P_ONE && flag_commit && !flag_issue) begin
                    taken_d = eval(cond_q, alu_flags);
                    state_d = RESP;
                end else
`endif
                // A zero count means flags already holds every committed write.
                if (pend_cnt == '0 && !flag_issue) begin
                    taken_d = eval(cond_q, flags);
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cond_eval_unit.sv
// tb_cond_eval_unit: scoreboard bench for cond_eval_unit.
// Expected results are queued when a request is driven and popped on response.
module tb_cond_eval_unit;

`ifdef COND_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] flags;
    logic [15:0] alu_flags;
    logic        flag_issue;
    logic        flag_commit;
    logic        req_valid;
    logic [3:0]  req_cond;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_taken;
    logic        resp_ready;
    logic [1:0]  pend_cnt;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    cond_eval_unit dut (
        .clk        (clk),
        .reset      (reset),
        .flags      (flags),
        .alu_flags  (alu_flags),
        .flag_issue (flag_issue),
        .flag_commit(flag_commit),
        .req_valid  (req_valid),
        .req_cond   (req_cond),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_taken (resp_taken),
        .resp_ready (resp_ready),
        .pend_cnt   (pend_cnt),
        .err        (err)
    );

    // Truth vector per flag word, bit i is the outcome of code i.
    function automatic logic model(input logic [3:0] c, input logic [15:0] f);
        logic z, cy, l, fv, n;
        logic [15:0] t;
        cy = f[0]; l = f[2]; fv = f[5]; z = f[6]; n = f[7];
        t = {1'b0, 1'b1, n | z, ~n & ~z, l | z, ~l & ~z, ~fv, fv,
             ~n, n, ~l, l, ~cy, cy, ~z, z};
        return t[c];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Present a request for one edge; afterwards the unit is in WAIT.
    task automatic send(input logic [3:0] c, input logic [15:0] f,
                        input logic [15:0] f_final, input logic rr,
                        input bit push);
        flags      = f;
        req_cond   = c;
        req_valid  = 1'b1;
        resp_ready = rr;
        if (push) exp_q.push_back(model(c, f_final));
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int max_cyc,
                             output int lat);
        lat = 0;
        while (!resp_valid && lat < max_cyc) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_valid"}, 32'(resp_valid), 1);
    endtask

    task automatic pop_cmp(input string tag);
        logic e;
        check({tag, "_qsz"}, 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_taken"}, 32'(resp_taken), 32'(e));
        end
    endtask

    task automatic simple(input string tag, input logic [3:0] c,
                          input logic [15:0] f);
        int lat;
        send(c, f, f, 1'b1, 1'b1);
        check({tag, "_busy"}, 32'(req_ready), 0);
        wait_resp(tag, 8, lat);
        check({tag, "_lat"}, lat, 1);
        pop_cmp(tag);
        @(negedge clk);
        check({tag, "_idle"}, 32'(req_ready), 1);
    endtask

    initial begin
        int lat;
        logic [15:0] pats [4];
        logic e;
        pats[0] = 16'h0000; pats[1] = 16'h0004;
        pats[2] = 16'h0080; pats[3] = 16'h0021;
        flags = '0; alu_flags = '0; flag_issue = 0; flag_commit = 0;
        req_valid = 0; req_cond = '0; resp_ready = 1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_rdy", 32'(req_ready), 1);
        check("rst_vld", 32'(resp_valid), 0);
        check("rst_tkn", 32'(resp_taken), 0);
        check("rst_pend", 32'(pend_cnt), 0);
        check("rst_err", 32'(err), 0);

        simple("eq", 4'd0, 16'h0040);
        simple("ne", 4'd1, 16'h0040);

        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 16; c++)
                simple($sformatf("sw_%0d_%0d", p, c), 4'(c), pats[p]);

        // Two writes in flight, committed one per cycle.
        do_reset();
        flag_issue = 1;
        @(negedge clk);
        @(negedge clk);
        flag_issue = 0;
        check("pd_two", 32'(pend_cnt), 2);
        send(4'd0, 16'h0000, 16'h0040, 1'b1, 1'b1);
        check("pd_w0", 32'(resp_valid), 0);
        @(negedge clk);
        check("pd_w1", 32'(resp_valid), 0);
        alu_flags = 16'h0040;
        flag_commit = 1;
        @(negedge clk);
        check("pd_one", 32'(pend_cnt), 1);
        check("pd_w2", 32'(resp_valid), 0);
        @(negedge clk);
        flag_commit = 0;
        flags = 16'h0040;
        check("pd_zero", 32'(pend_cnt), 0);
        wait_resp("pd", 4, lat);
        check("pd_lat", lat, BYP ? 0 : 1);
        pop_cmp("pd");
        @(negedge clk);

        // Backpressure holds the response.
        send(4'd13, 16'h0080, 16'h0080, 1'b0, 1'b1);
        e = model(4'd13, 16'h0080);
        wait_resp("bp", 8, lat);
        pop_cmp("bp");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_vld", 32'(resp_valid), 1);
            check("bp_tkn", 32'(resp_taken), 32'(e));
            check("bp_rdy", 32'(req_ready), 0);
        end
        resp_ready = 1;
        @(negedge clk);
        check("bp_idle", 32'(req_ready), 1);
        check("bp_drop", 32'(resp_valid), 0);

        // Counter saturation and underflow.
        do_reset();
        flag_issue = 1;
        repeat (3) @(negedge clk);
        check("sat_3", 32'(pend_cnt), 3);
        check("sat_e0", 32'(err), 0);
        @(negedge clk);
        flag_issue = 0;
        check("sat_hold", 32'(pend_cnt), 3);
        check("sat_err", 32'(err), 1);
        do_reset();
        check("clr_err", 32'(err), 0);
        check("clr_pend", 32'(pend_cnt), 0);
        flag_issue = 1;
        flag_commit = 1;
        @(negedge clk);
        flag_issue = 0;
        check("both_pend", 32'(pend_cnt), 0);
        check("both_err", 32'(err), 0);
        @(negedge clk);
        flag_commit = 0;
        check("und_pend", 32'(pend_cnt), 0);
        check("und_err", 32'(err), 1);

        // Reset while waiting drops the request.
        do_reset();
        flag_issue = 1;
        @(negedge clk);
        flag_issue = 0;
        send(4'd0, 16'h0040, 16'h0040, 1'b1, 1'b0);
        check("rw_busy", 32'(req_ready), 0);
        do_reset();
        check("rw_rdy", 32'(req_ready), 1);
        check("rw_vld", 32'(resp_valid), 0);
        check("rw_pend", 32'(pend_cnt), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rw_none", 32'(resp_valid), 0);
        end
        check("rw_q", exp_q.size(), 0);

        // Last pending write commits while a request waits.
        flag_issue = 1;
        @(negedge clk);
        flag_issue = 0;
        send(4'd0, 16'h0000, 16'h0040, 1'b1, 1'b1);
        alu_flags = 16'h0040;
        flag_commit = 1;
        @(negedge clk);
        flag_commit = 0;
        flags = 16'h0040;
        check("by_vld", 32'(resp_valid), BYP);
        wait_resp("by", 4, lat);
        check("by_lat", lat, BYP ? 0 : 1);
        pop_cmp("by");
        @(negedge clk);
        check("by_idle", 32'(req_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
